// File: rtl/au_pkg.sv
// ---------------------------------------------------------------------------
// au_pkg
//
// Shared types and constants for the AU result stage.
//
//   AU_W        width of the AU result word
//   au_flags_t  condition flags carried with each result {z, n, v, c}
//   au_entry_t  one buffered result: {res, flags, op_sel}
//   AU_ENTRY_W  packed width of au_entry_t (storage width of the FIFO)
//   au_make_entry()  builds an entry from raw AU outputs, deriving z
// ---------------------------------------------------------------------------
package au_pkg;

    localparam int AU_W = 16;

    typedef struct packed {
        logic z;
        logic n;
        logic v;
        logic c;
    } au_flags_t;

    typedef struct packed {
        logic [AU_W-1:0] res;
        au_flags_t       flags;
        logic            op_sel;
    } au_entry_t;

    localparam int AU_ENTRY_W = $bits(au_entry_t);

    // The AU itself does not produce a zero flag; it is derived here, once,
    // when the result is captured, so consumers never see a stale z.
    function automatic au_entry_t au_make_entry(
        input logic [AU_W-1:0] res,
        input logic            n,
        input logic            v,
        input logic            c,
        input logic            op_sel
    );
        au_entry_t e;
        e.res     = res;
        e.flags.z = (res == '0);
        e.flags.n = n;
        e.flags.v = v;
        e.flags.c = c;
        e.op_sel  = op_sel;
        return e;
    endfunction

endpackage : au_pkg

// File: rtl/au_entry_fifo.sv
// ---------------------------------------------------------------------------
// au_entry_fifo
//
// Small synchronous FIFO with valid/ready handshaking on both sides.
// in_ready and out_valid are decoded from the registered occupancy only, so
// there is no combinational path from out_ready to in_ready and none from
// in_* to out_*.
//
// Parameters
//   DEPTH  number of entries; power of two, 2..8
//   WIDTH  entry width in bits
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     producer presents in_data
//   in_ready     FIFO not full
//   in_data      entry to write
//   out_valid    FIFO not empty; out_data is the head entry
//   out_ready    consumer takes the head entry
//   out_data     head entry
//   count        occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module au_entry_fifo
    import au_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = AU_ENTRY_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    // A full FIFO refuses a push even if the head is popped in the same
    // cycle; this keeps in_ready independent of out_ready.
    assign in_ready  = (count != FULL_CNT);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = mem[rd_ptr];

    // NOTE: the storage array is reset like any other flop so the outputs
    // read as zero after reset instead of X; at this depth the cost is
    // negligible and it makes the reset state fully defined.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // NOTE: all sequential state is assigned with non-blocking (<=) so every
    // flop samples the pre-edge values regardless of statement order.
    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule : au_entry_fifo

// File: rtl/au_result_stage.sv
// ---------------------------------------------------------------------------
// au_result_stage
//
// Registered output stage behind the 16-bit add/sub AU. Each accepted AU
// result is captured together with its flags (z derived at capture) and
// op_sel into a small FIFO so writeback or the flag consumer can stall.
// A saturating counter records how many accepted results had overflow.
//
// Optional feature (compile-time macro AU_STICKY_FLAGS_EN):
//   adds sticky_v / sticky_c / sticky_z, OR-accumulated over accepted pushes
//   and cleared by clr. Without the macro these ports do not exist.
//
// Parameters
//   W      result width; must equal au_pkg::AU_W
//   DEPTH  FIFO entries; power of two, 2..8
//   CNT_W  width of the overflow-event counter
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  upstream handshake
//   in_res, in_v, in_c, in_n, in_op_sel   AU result and flags
//   out_valid / out_ready                 downstream handshake
//   out_res, out_z, out_n, out_v, out_c, out_op_sel   head entry
//   count                FIFO occupancy
//   ovf_cnt              accepted entries with v=1, saturating
//   clr                  synchronous clear of ovf_cnt (and sticky flags)
// ---------------------------------------------------------------------------
module au_result_stage
    import au_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_res,
    input  logic                   in_v,
    input  logic                   in_c,
    input  logic                   in_n,
    input  logic                   in_op_sel,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W-1:0]           out_res,
    output logic                   out_z,
    output logic                   out_n,
    output logic                   out_v,
    output logic                   out_c,
    output logic                   out_op_sel,
    output logic [$clog2(DEPTH):0] count,
    output logic [CNT_W-1:0]       ovf_cnt,
    input  logic                   clr
`ifdef AU_STICKY_FLAGS_EN
    ,
    output logic                   sticky_v,
    output logic                   sticky_c,
    output logic                   sticky_z
`endif
);

    localparam logic [CNT_W-1:0] OVF_MAX = '1;

    au_entry_t        in_entry;
    au_entry_t        head;
    logic             push;
    logic [CNT_W-1:0] ovf_base;
    logic [CNT_W-1:0] ovf_next;

    assign in_entry = au_make_entry(in_res, in_n, in_v, in_c, in_op_sel);
    assign push     = in_valid && in_ready;

    au_entry_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (AU_ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head),
        .count     (count)
    );

    assign out_res    = head.res;
    assign out_z      = head.flags.z;
    assign out_n      = head.flags.n;
    assign out_v      = head.flags.v;
    assign out_c      = head.flags.c;
    assign out_op_sel = head.op_sel;

    // clr wins over the old count but not over a coincident overflow push:
    // the cleared value is the base, and that push still counts on top of it.
    // NOTE: combinational blocks assign every output a default first so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        ovf_base = clr ? '0 : ovf_cnt;
        ovf_next = ovf_base;
        if (push && in_v && (ovf_base != OVF_MAX)) begin
            ovf_next = ovf_base + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt <= '0;
        end else begin
            ovf_cnt <= ovf_next;
        end
    end

`ifdef AU_STICKY_FLAGS_EN
    // On clr the history is dropped; a push in the same cycle seeds the
    // flags with that entry's values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_v <= 1'b0;
            sticky_c <= 1'b0;
            sticky_z <= 1'b0;
        end else if (clr) begin
            sticky_v <= push && in_entry.flags.v;
            sticky_c <= push && in_entry.flags.c;
            sticky_z <= push && in_entry.flags.z;
        end else if (push) begin
            sticky_v <= sticky_v | in_entry.flags.v;
            sticky_c <= sticky_c | in_entry.flags.c;
            sticky_z <= sticky_z | in_entry.flags.z;
        end
    end
`endif

endmodule : au_result_stage

// File: tb/tb_au_result_stage.sv
// ---------------------------------------------------------------------------
// tb_au_result_stage
//
// Scoreboard bench for au_result_stage (DEPTH=2, CNT_W=8). Inputs change 1 ns
// after the rising edge; a monitor on the falling edge compares the DUT head
// entry, occupancy and overflow count against a queue model, then updates
// the model with the push/pop that the next rising edge will perform.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_au_result_stage;
    import au_pkg::*;

    localparam int W       = 16;
    localparam int DEPTH   = 2;
    localparam int CNT_W   = 8;
    localparam int OVF_MAX = (1 << CNT_W) - 1;

    logic                   clk;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [W-1:0]           in_res;
    logic                   in_v;
    logic                   in_c;
    logic                   in_n;
    logic                   in_op_sel;
    logic                   out_valid;
    logic                   out_ready;
    logic [W-1:0]           out_res;
    logic                   out_z;
    logic                   out_n;
    logic                   out_v;
    logic                   out_c;
    logic                   out_op_sel;
    logic [$clog2(DEPTH):0] count;
    logic [CNT_W-1:0]       ovf_cnt;
    logic                   clr;
`ifdef AU_STICKY_FLAGS_EN
    logic                   sticky_v;
    logic                   sticky_c;
    logic                   sticky_z;
`endif

    au_result_stage #(
        .W     (W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_res     (in_res),
        .in_v       (in_v),
        .in_c       (in_c),
        .in_n       (in_n),
        .in_op_sel  (in_op_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_res    (out_res),
        .out_z      (out_z),
        .out_n      (out_n),
        .out_v      (out_v),
        .out_c      (out_c),
        .out_op_sel (out_op_sel),
        .count      (count),
        .ovf_cnt    (ovf_cnt),
        .clr        (clr)
`ifdef AU_STICKY_FLAGS_EN
        ,
        .sticky_v   (sticky_v),
        .sticky_c   (sticky_c),
        .sticky_z   (sticky_z)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int        total = 0;
    int        bad   = 0;
    au_entry_t sb[$];
    int        m_ovf = 0;
    bit        mon_en = 1'b0;
    int        mon_n;
    bit        mon_acc;
    au_entry_t mon_e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [W-1:0] r, input logic v,
                         input logic c, input logic n, input logic op);
        in_valid  = vld;
        in_res    = r;
        in_v      = v;
        in_c      = c;
        in_n      = n;
        in_op_sel = op;
    endtask

    // Falling-edge monitor: compare current state, then apply the transfer
    // the coming rising edge performs to the model.
    always @(negedge clk) begin
        if (mon_en) begin
            mon_n = sb.size();
            check("count",     count,     mon_n);
            check("in_ready",  in_ready,  mon_n != DEPTH);
            check("out_valid", out_valid, mon_n != 0);
            check("ovf_cnt",   ovf_cnt,   m_ovf);
            if (mon_n != 0) begin
                mon_e = sb[0];
                check("out_res",    out_res,    mon_e.res);
                check("out_z",      out_z,      mon_e.flags.z);
                check("out_n",      out_n,      mon_e.flags.n);
                check("out_v",      out_v,      mon_e.flags.v);
                check("out_c",      out_c,      mon_e.flags.c);
                check("out_op_sel", out_op_sel, mon_e.op_sel);
                if (out_ready) void'(sb.pop_front());
            end
            mon_acc = in_valid && (mon_n != DEPTH);
            if (mon_acc) begin
                mon_e.res     = in_res;
                mon_e.flags.z = (in_res == 16'h0000);
                mon_e.flags.n = in_n;
                mon_e.flags.v = in_v;
                mon_e.flags.c = in_c;
                mon_e.op_sel  = in_op_sel;
                sb.push_back(mon_e);
            end
            if (clr)
                m_ovf = (mon_acc && in_v) ? 1 : 0;
            else if (mon_acc && in_v && m_ovf != OVF_MAX)
                m_ovf = m_ovf + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        clr       = 1'b0;
        out_ready = 1'b0;
        drive(0, 16'h0, 0, 0, 0, 0);

        // Reset state while rst_n is still low
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_count",     count,     0);
        check("rst_ovf",       ovf_cnt,   0);
        check("rst_out_res",   out_res,   0);
        #9;
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);
        mon_en = 1'b1;
        step();

        // Single push of zero result: z derived, c/op_sel carried
        out_ready = 1'b1;
        drive(1, 16'h0000, 0, 1, 0, 1);
        step();
        drive(0, 16'h0, 0, 0, 0, 0);
        @(negedge clk);
        check("t1_out_valid", out_valid, 1);
        check("t1_out_z",     out_z,     1);
        check("t1_out_c",     out_c,     1);
        step();
        @(negedge clk);
        check("t1_drained", count, 0);
        step();

        // Fill with consumer stalled; third push must be ignored
        out_ready = 1'b0;
        drive(1, 16'h1234, 0, 0, 0, 0); step();
        drive(1, 16'h8000, 0, 0, 1, 1); step();
        drive(1, 16'h5555, 0, 1, 0, 0); step();
        step();
        @(negedge clk);
        check("t2_full_count", count,    2);
        check("t2_in_ready",   in_ready, 0);
        check("t2_head_held",  out_res,  16'h1234);
        step();
        drive(0, 16'h0, 0, 0, 0, 0);
        out_ready = 1'b1;
        repeat (3) step();

        // Full FIFO with push and pop in the same cycle: push refused
        out_ready = 1'b0;
        drive(1, 16'h00A1, 0, 0, 0, 0); step();
        drive(1, 16'h00A2, 0, 0, 0, 0); step();
        drive(1, 16'hAAAA, 1, 0, 1, 1);
        out_ready = 1'b1;
        step();
        @(negedge clk);
        check("t3_count_after_pop", count, 1);
        step();
        drive(0, 16'h0, 0, 0, 0, 0);
        repeat (3) step();

        // Steady streaming 1..10
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            drive(1, W'(i), 0, i[0], i[1], i[2]);
            step();
        end
        drive(0, 16'h0, 0, 0, 0, 0);
        repeat (2) step();

        // Overflow counter saturation and clr priority
        clr = 1'b1; step(); clr = 1'b0;
        for (int i = 0; i < 260; i++) begin
            drive(1, W'(i + 1), 1, 0, 0, 0);
            step();
        end
        drive(0, 16'h0, 0, 0, 0, 0);
        step();
        @(negedge clk);
        check("t5_ovf_sat", ovf_cnt, OVF_MAX);
        step();
        clr = 1'b1;
        drive(1, 16'h7FFF, 1, 0, 0, 0);
        step();
        clr = 1'b0;
        drive(0, 16'h0, 0, 0, 0, 0);
        @(negedge clk);
        check("t5_clr_push", ovf_cnt, 1);
        step();
        step();

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 1), W'($urandom_range(0, 3) == 0 ? 0 : $urandom),
                  $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 1));
            out_ready = $urandom_range(0, 1);
            clr       = ($urandom_range(0, 15) == 0);
            step();
        end
        drive(0, 16'h0, 0, 0, 0, 0);
        clr       = 1'b0;
        out_ready = 1'b1;
        repeat (DEPTH + 2) step();

        // Asynchronous reset mid-stream with count=2
        out_ready = 1'b0;
        drive(1, 16'h0BAD, 1, 1, 1, 1); step();
        drive(1, 16'h0C0D, 1, 0, 0, 0); step();
        drive(0, 16'h0, 0, 0, 0, 0);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_count",     count,     0);
        check("arst_ovf",       ovf_cnt,   0);
        check("arst_out_res",   out_res,   0);
        sb.delete();
        m_ovf = 0;
        @(negedge clk);
        #2;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        step();

        // Stage works again after reset
        out_ready = 1'b1;
        drive(1, 16'hFFFF, 0, 1, 1, 0); step();
        drive(0, 16'h0, 0, 0, 0, 0);
        repeat (3) step();
        @(negedge clk);
        check("final_count", count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_au_result_stage

// File: doc/au_result_stage.md
Name: au_result_stage

Overview:
- Registered output stage directly downstream of the 16-bit add/sub arithmetic unit.
- Captures the AU result word and its v/c/n flags and derives the zero flag at capture.
- Buffers entries in a small FIFO with valid/ready handshaking, so writeback or the flag consumer can stall without losing AU results.
- Keeps a saturating overflow-event counter for debug and status reads.

Parameters:
- W, 16, data width of the result word; must match the AU width.
- DEPTH, 2, FIFO entries; power of two, 2 to 8.
- CNT_W, 8, width of the overflow-event counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  AU result presented this cycle.
- in_ready  out  1  stage can accept an entry.
- in_res  in  W  AU result.
- in_v  in  1  AU overflow flag.
- in_c  in  1  AU carry-out.
- in_n  in  1  AU sign/less-than flag.
- in_op_sel  in  1  0 = add, 1 = subtract; stored with the entry.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts the head entry.
- out_res  out  W  head result.
- out_z  out  1  head zero flag.
- out_n  out  1  head n flag.
- out_v  out  1  head v flag.
- out_c  out  1  head c flag.
- out_op_sel  out  1  head op_sel.
- count  out  clog2(DEPTH)+1  FIFO occupancy.
- ovf_cnt  out  CNT_W  accepted entries with v=1; saturating.
- clr  in  1  synchronous clear of ovf_cnt (and sticky flags when enabled).

Behaviour:
- Reset (rst_n low, asynchronous):
  - count, read/write pointers and ovf_cnt go to 0.
  - out_valid is 0.
  - All storage is 0, so out_res/flags/op_sel read 0.
  - in_ready is 1 once rst_n is high.
  - Reset mid-transfer discards all buffered entries.
- Push: when in_valid && in_ready, write {in_res, z, in_n, in_v, in_c, in_op_sel} at the write pointer.
  - z = (in_res == 0), computed at capture; n/v/c stored unmodified.
- Pop: when out_valid && out_ready, advance the read pointer.
- in_ready = (count != DEPTH). It is combinational from registered count and has no dependence on out_ready; a full FIFO does not admit a push even when a pop occurs in the same cycle.
- out_valid = (count != 0). out_* are driven from the head storage entry.
- Latency: an entry pushed into an empty FIFO appears on out_* with out_valid=1 in the next cycle. There is no combinational in-to-out path.
- Simultaneous push and pop (not full, not empty): count is unchanged and both pointers advance.
- Pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
- count updates +1 on push only, -1 on pop only, unchanged otherwise.
- in_valid while in_ready=0 is ignored; the upstream holds the data.
- out_* remain stable while out_valid && !out_ready.
- ovf_cnt:
  - On an accepted push with in_v=1, increments unless all ones; saturates at 2^CNT_W-1.
  - clr forces 0; clr has priority.
  - clr coincident with an accepted v=1 push gives ovf_cnt = 1.
- A pop never modifies ovf_cnt.

Optional Feature:
- Macro: AU_STICKY_FLAGS_EN.
- Defined:
  - Adds outputs sticky_v, sticky_c, sticky_z (1 bit each), reset to 0.
  - Each is OR-accumulated over accepted pushes.
  - clr clears them; on clr plus push in the same cycle, each takes the pushed entry's value.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package au_pkg:
  - AU_W = 16.
  - Typedef au_flags_t {z, n, v, c}.
  - Typedef au_entry_t {res[AU_W-1:0], au_flags_t flags, op_sel}.
  - Constant AU_ENTRY_W.
- Sub-module au_entry_fifo (parameter DEPTH, entry width):
  - Holds the storage array, pointers, count and the in_ready/out_valid logic.
  - au_result_stage wraps it and adds z derivation, ovf_cnt and sticky flags.

Test Plan:
- Reset, then single push res=0x0000, v=0, c=1, n=0, op_sel=1, out_ready=1 → next cycle out_valid=1, out_res=0x0000, out_z=1, out_c=1; following cycle out_valid=0, count=0.
- out_ready=0, push 0x1234 then 0x8000 (DEPTH=2) → count=2, in_ready=0; third push 0x5555 ignored; release out_ready → pops 0x1234 then 0x8000 in order, never 0x5555.
- Full FIFO with in_valid=1 and out_ready=1 in the same cycle → pop occurs, push refused that cycle; count 2→1, then the push is accepted next cycle.
- Steady streaming with in_valid=out_ready=1 for 10 cycles, values 1..10 → outputs 1..10 one per cycle after 1-cycle latency; count stays 1; pointers wrap without loss.
- 260 pushes with v=1, CNT_W=8 → ovf_cnt saturates at 255; clr with a simultaneous v=1 push → ovf_cnt=1.
- rst_n asserted low mid-stream with count=2 → out_valid=0, count=0 and ovf_cnt=0 immediately (asynchronous), before the next clk edge.
